// File: rtl/pixel_serializer_if.sv
// Word-in / pixel-out bus for pixel_serializer: ready/valid word input
// plus the delay-line shift enable, pixel and block-complete pulse.
interface pixel_serializer_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned NPIX  = 4
);
  logic                    in_valid;
  logic [PIX_W*NPIX-1:0]   in_data;
  logic                    in_last;
  logic                    in_ready;
  logic                    out_en;
  logic [PIX_W-1:0]        out_pix;
  logic                    done;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_en, out_pix, done
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_en, out_pix, done
  );
endinterface

// File: rtl/pixel_serializer.sv
// Serializes NPIX-pixel words into one pixel per clock for a delay-line
// chain, then drains FLUSH_LEN zero pixels after the last word of a block.
module pixel_serializer #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned NPIX      = 4,
  parameter int unsigned FLUSH_LEN = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  pixel_serializer_if.slave  bus
);

  localparam int unsigned IW  = $clog2(NPIX);
  localparam int unsigned FCW = (FLUSH_LEN < 2) ? 1 : $clog2(FLUSH_LEN);
  localparam logic [IW-1:0]  ILAST = IW'(NPIX - 1);
  localparam logic [FCW-1:0] FLAST = FCW'((FLUSH_LEN == 0) ? 0 : FLUSH_LEN - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

  state_t                       state;
  logic [IW-1:0]                idx;
  logic [FCW-1:0]               fcnt;
  logic [NPIX-1:0][PIX_W-1:0]   buffer;
  logic                         last;

  logic [IW-1:0]                idx_inc;
  logic                         accept;
  logic [NPIX-1:0][PIX_W-1:0]   in_word;

  always_comb begin
    idx_inc = idx + 1'b1;
    accept  = bus.in_valid & bus.in_ready;
    in_word = bus.in_data;
  end

  // Outputs are registered alongside the state, so each branch sets the
  // values the next cycle presents rather than decoding them afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      fcnt         <= '0;
      buffer       <= '0;
      last         <= 1'b0;
      bus.in_ready <= 1'b1;
      bus.out_en   <= 1'b0;
      bus.out_pix  <= '0;
      bus.done     <= 1'b0;
    end else if (clr) begin
      state        <= IDLE;
      idx          <= '0;
      fcnt         <= '0;
      buffer       <= '0;
      last         <= 1'b0;
      bus.in_ready <= 1'b1;
      bus.out_en   <= 1'b0;
      bus.out_pix  <= '0;
      bus.done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (accept) begin
            state        <= SHIFT;
            buffer       <= in_word;
            last         <= bus.in_last;
            idx          <= '0;
            bus.in_ready <= 1'b0;
            bus.out_en   <= 1'b1;
            bus.out_pix  <= in_word[0];
          end
        end

        SHIFT: begin
          if (idx == ILAST) begin
            if (last) begin
              last <= 1'b0;
              idx  <= '0;
              if (FLUSH_LEN == 0) begin
                state        <= IDLE;
                bus.in_ready <= 1'b1;
                bus.out_en   <= 1'b0;
                bus.out_pix  <= '0;
                bus.done     <= 1'b1;
              end else begin
                state        <= FLUSH;
                fcnt         <= '0;
                bus.in_ready <= 1'b0;
                bus.out_en   <= 1'b1;
                bus.out_pix  <= '0;
              end
            end else if (accept) begin
              // Back-to-back word: no bubble between the two pixel runs.
              buffer       <= in_word;
              last         <= bus.in_last;
              idx          <= '0;
              bus.in_ready <= 1'b0;
              bus.out_en   <= 1'b1;
              bus.out_pix  <= in_word[0];
            end else begin
              state        <= IDLE;
              idx          <= '0;
              bus.in_ready <= 1'b1;
              bus.out_en   <= 1'b0;
              bus.out_pix  <= '0;
            end
          end else begin
            idx          <= idx_inc;
            bus.out_pix  <= buffer[idx_inc];
            bus.in_ready <= (idx_inc == ILAST) && !last;
          end
        end

        FLUSH: begin
          if (fcnt == FLAST) begin
            state        <= IDLE;
            fcnt         <= '0;
            bus.in_ready <= 1'b1;
            bus.out_en   <= 1'b0;
            bus.out_pix  <= '0;
            bus.done     <= 1'b1;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
          bus.out_en   <= 1'b0;
          bus.out_pix  <= '0;
          bus.done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed plus randomized checks of pixel_serializer with FLUSH_LEN=3 and
// FLUSH_LEN=0 instances; random traffic is scored against a pixel-stream queue.
module tb_pixel_serializer;

  localparam int unsigned PW = 8;
  localparam int unsigned NP = 4;
  localparam int unsigned FL = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  always #5 clk = ~clk;

  pixel_serializer_if #(.PIX_W(PW), .NPIX(NP)) bus3 ();
  pixel_serializer_if #(.PIX_W(PW), .NPIX(NP)) bus0 ();

  pixel_serializer #(.PIX_W(PW), .NPIX(NP), .FLUSH_LEN(FL)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus3)
  );

  pixel_serializer #(.PIX_W(PW), .NPIX(NP), .FLUSH_LEN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus0)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  bit                sb_on     = 1'b0;
  logic [PW-1:0]     exp_q[$];
  int unsigned       done_seen = 0;
  int unsigned       exp_done  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix_of(input logic [31:0] w, input int unsigned k);
    return PW'((w >> (PW * k)) & 32'hFF);
  endfunction

  // One clock: returns at the falling edge, where outputs are stable.
  task automatic tick();
    @(negedge clk);
    if (sb_on) begin
      if (bus3.out_en === 1'b1) begin
        check("sb_pixel_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("sb_pixel", 32'(bus3.out_pix), 32'(exp_q.pop_front()));
      end
      if (bus3.done === 1'b1) done_seen++;
    end
  endtask

  task automatic expect_pixels(input string tag, input logic [31:0] w, input int ready_at);
    for (int k = 0; k < int'(NP); k++) begin
      check({tag, "_en"},    32'(bus3.out_en),   32'd1);
      check({tag, "_pix"},   32'(bus3.out_pix),  32'(pix_of(w, k)));
      check({tag, "_ready"}, 32'(bus3.in_ready), 32'(k == ready_at));
      check({tag, "_done"},  32'(bus3.done),     32'd0);
      tick();
    end
  endtask

  task automatic expect_flush_done(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      check({tag, "_fl_en"},    32'(bus3.out_en),   32'd1);
      check({tag, "_fl_pix"},   32'(bus3.out_pix),  32'd0);
      check({tag, "_fl_ready"}, 32'(bus3.in_ready), 32'd0);
      check({tag, "_fl_done"},  32'(bus3.done),     32'd0);
      tick();
    end
    check({tag, "_done"},      32'(bus3.done),     32'd1);
    check({tag, "_idle_en"},   32'(bus3.out_en),   32'd0);
    check({tag, "_idle_rdy"},  32'(bus3.in_ready), 32'd1);
    tick();
    check({tag, "_done_once"}, 32'(bus3.done),     32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic        lst;
    bit          acc;
    int unsigned gap;

    rst_n = 1'b0;
    clr   = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.in_last = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_last = 1'b0;

    #12;
    check("rst_ready", 32'(bus3.in_ready), 32'd1);
    check("rst_en",    32'(bus3.out_en),   32'd0);
    check("rst_pix",   32'(bus3.out_pix),  32'd0);
    check("rst_done",  32'(bus3.done),     32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(bus3.in_ready), 32'd1);
    check("idle_en",    32'(bus3.out_en),   32'd0);

    // Single last word, FLUSH_LEN=3; in_data scrambled after acceptance.
    bus3.in_valid = 1'b1; bus3.in_data = 32'h44332211; bus3.in_last = 1'b1;
    tick();
    bus3.in_valid = 1'b0; bus3.in_data = 32'hDEADBEEF; bus3.in_last = 1'b0;
    expect_pixels("single", 32'h44332211, -1);
    expect_flush_done("single", 3);

    // Back-to-back words with in_valid held.
    bus3.in_valid = 1'b1; bus3.in_data = 32'hA3A2A1A0; bus3.in_last = 1'b0;
    tick();
    bus3.in_data = 32'hB3B2B1B0; bus3.in_last = 1'b1;
    expect_pixels("b2b_a", 32'hA3A2A1A0, 3);
    bus3.in_valid = 1'b0;
    expect_pixels("b2b_b", 32'hB3B2B1B0, -1);
    expect_flush_done("b2b", 3);

    // Second word offered two cycles after the final pixel of the first.
    bus3.in_valid = 1'b1; bus3.in_data = 32'hA3A2A1A0; bus3.in_last = 1'b0;
    tick();
    bus3.in_valid = 1'b0; bus3.in_data = 32'h0;
    expect_pixels("gap_a", 32'hA3A2A1A0, 3);
    check("gap_bubble1_en",  32'(bus3.out_en),   32'd0);
    check("gap_bubble1_rdy", 32'(bus3.in_ready), 32'd1);
    tick();
    check("gap_bubble2_en",  32'(bus3.out_en),   32'd0);
    bus3.in_valid = 1'b1; bus3.in_data = 32'hB3B2B1B0; bus3.in_last = 1'b1;
    tick();
    bus3.in_valid = 1'b0;
    expect_pixels("gap_b", 32'hB3B2B1B0, -1);
    expect_flush_done("gap", 3);

    // Asynchronous reset during the 0x33 pixel.
    bus3.in_valid = 1'b1; bus3.in_data = 32'h44332211; bus3.in_last = 1'b1;
    tick();
    bus3.in_valid = 1'b0;
    tick();
    tick();
    check("rstmid_pix33", 32'(bus3.out_pix), 32'h33);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_en",    32'(bus3.out_en),   32'd0);
    check("rstmid_pix",   32'(bus3.out_pix),  32'd0);
    check("rstmid_ready", 32'(bus3.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rstmid_after_done",  32'(bus3.done),     32'd0);
      check("rstmid_after_en",    32'(bus3.out_en),   32'd0);
      check("rstmid_after_ready", 32'(bus3.in_ready), 32'd1);
    end

    // Synchronous clear in the second flush cycle with a word offered.
    bus3.in_valid = 1'b1; bus3.in_data = 32'h44332211; bus3.in_last = 1'b1;
    tick();
    bus3.in_valid = 1'b0;
    expect_pixels("clr_a", 32'h44332211, -1);
    check("clr_fl1_en", 32'(bus3.out_en), 32'd1);
    tick();
    check("clr_fl2_en", 32'(bus3.out_en), 32'd1);
    clr = 1'b1;
    bus3.in_valid = 1'b1; bus3.in_data = 32'h55667788; bus3.in_last = 1'b1;
    tick();
    check("clr_en",    32'(bus3.out_en),   32'd0);
    check("clr_done",  32'(bus3.done),     32'd0);
    check("clr_ready", 32'(bus3.in_ready), 32'd1);
    clr = 1'b0;
    tick();
    bus3.in_valid = 1'b0;
    expect_pixels("clr_b", 32'h55667788, -1);
    expect_flush_done("clr_b", 3);

    // FLUSH_LEN=0 instance: done directly after the fourth pixel.
    bus0.in_valid = 1'b1; bus0.in_data = 32'hD3D2D1D0; bus0.in_last = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    for (int k = 0; k < int'(NP); k++) begin
      check("nf_en",   32'(bus0.out_en),  32'd1);
      check("nf_pix",  32'(bus0.out_pix), 32'(pix_of(32'hD3D2D1D0, k)));
      check("nf_done", 32'(bus0.done),    32'd0);
      tick();
    end
    check("nf_done_pulse", 32'(bus0.done),     32'd1);
    check("nf_idle_en",    32'(bus0.out_en),   32'd0);
    check("nf_idle_rdy",   32'(bus0.in_ready), 32'd1);
    tick();
    check("nf_done_once",  32'(bus0.done),     32'd0);

    // Randomized traffic: expected pixel stream is each accepted word's
    // pixels in order, followed by FL zeros after every last word.
    sb_on = 1'b1;
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < int'(gap); g++) begin
        bus3.in_valid = 1'b0;
        bus3.in_data  = $urandom;
        bus3.in_last  = 1'($urandom);
        tick();
      end
      w   = $urandom;
      lst = (n == 39) || ($urandom_range(0, 2) == 0);
      bus3.in_valid = 1'b1; bus3.in_data = w; bus3.in_last = lst;
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) begin
        acc = bus3.in_ready;
        if (acc) begin
          for (int k = 0; k < int'(NP); k++) exp_q.push_back(pix_of(w, k));
          if (lst) begin
            for (int k = 0; k < int'(FL); k++) exp_q.push_back('0);
            exp_done++;
          end
        end
        tick();
      end
      check("rnd_accept", 32'(acc), 32'd1);
    end
    bus3.in_valid = 1'b0;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || done_seen != exp_done); i++) tick();
    sb_on = 1'b0;
    check("rnd_drained",   32'(exp_q.size()), 32'd0);
    check("rnd_done_count", done_seen,        exp_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_serializer.md
PIXEL_SERIALIZER -- requirements
Module: pixel_serializer

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning bits per pixel.
REQ-002 SHALL have parameter NPIX, default 4, meaning pixels per input word; legal values are 2 or more.
REQ-003 SHALL have parameter FLUSH_LEN, default 16, meaning zero-pixel drain cycles after the last word; legal values are 0 or more.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port clr, input, 1 bit: synchronous abort.
REQ-007 SHALL have port in_valid, input, 1 bit: input word valid.
REQ-008 SHALL have port in_data, input, PIX_W*NPIX bits: packed pixels, pixel 0 in the LSBs.
REQ-009 SHALL have port in_last, input, 1 bit: marks the final word of a block; sampled with in_data.
REQ-010 SHALL have port in_ready, output, 1 bit: word accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-011 SHALL have port out_en, output, 1 bit: shift enable to the downstream delay-line chain.
REQ-012 SHALL have port out_pix, output, PIX_W bits: pixel presented with out_en.
REQ-013 SHALL have port done, output, 1 bit: single-cycle block-complete pulse.

Function
REQ-014 SHALL implement states IDLE, SHIFT and FLUSH, with a pixel index idx (0..NPIX-1), a flush counter fcnt, a word buffer and a held last flag.
REQ-015 SHALL, in IDLE, drive in_ready=1, out_en=0 and out_pix=0.
REQ-016 SHALL, on acceptance in IDLE, load in_data to the buffer, capture in_last, set idx=0 and enter SHIFT; the first pixel appears in the cycle after the accepting edge (latency 1).
REQ-017 SHALL, in SHIFT, drive out_en=1 and out_pix=buffer pixel[idx], then increment idx at each edge.
REQ-018 SHALL drive in_ready in SHIFT to 1 only when idx==NPIX-1 and the held last flag is 0; otherwise in_ready SHALL be 0 in SHIFT.
REQ-019 SHALL handle the edge where idx==NPIX-1 as follows: if last=1, enter FLUSH with fcnt=0 (or go to IDLE with done pulse if FLUSH_LEN==0); else if in_valid=1, load the next word with idx=0 and stay in SHIFT, giving no bubble; else go to IDLE.
REQ-020 SHALL, in FLUSH, drive out_en=1, out_pix=0 and in_ready=0 for exactly FLUSH_LEN cycles, then go to IDLE.
REQ-021 SHALL assert done=1 for exactly one cycle: the first IDLE cycle after the final flush cycle (or after the final pixel when FLUSH_LEN==0).
REQ-022 SHALL ignore in_data and in_last when no acceptance occurs; changes to in_data while in_ready=0 SHALL NOT affect out_pix.
REQ-023 SHALL give clr=1 priority over every other transition: at the next edge go to IDLE with idx=0, fcnt=0 and the buffer cleared; done SHALL NOT pulse for an aborted block, and a word offered in the same cycle SHALL NOT be accepted.
REQ-024 SHALL size the idx and fcnt counters so they never wrap within a word or a flush, for any legal parameter value.
REQ-025 SHALL drive all outputs from flops or from state-decoded flops only, with no combinational path from in_valid to out_en or out_pix.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state=IDLE, idx=0, fcnt=0, buffer=0, last=0, out_en=0, out_pix=0 and done=0, and set in_ready=1.
REQ-027 SHALL discard any partially shifted word or flush in progress when reset is asserted, and resume at IDLE after release.

Verification
REQ-028 SHALL be verified (PIX_W=8, NPIX=4, FLUSH_LEN=3) with single word 0x44332211 and in_last=1 -> out_pix 0x11, 0x22, 0x33, 0x44 on 4 consecutive out_en cycles, then 3 cycles of out_en=1 with out_pix=0, then done=1 for one cycle, with in_ready=1 from that cycle.
REQ-029 SHALL be verified with 0xA3A2A1A0 (last=0) then 0xB3B2B1B0 (last=1), in_valid held -> 8 contiguous out_en cycles A0..A3, B0..B3; in_ready=1 only in IDLE and in the A3 cycle.
REQ-030 SHALL be verified with the second word offered 2 cycles after the A3 cycle -> out_en=0 for at least 2 cycles, then B0 in the cycle after acceptance.
REQ-031 SHALL be verified with rst_n pulsed low during the 0x33 cycle -> out_en=0 and out_pix=0 immediately, no done pulse, and in_ready=1 after release.
REQ-032 SHALL be verified with clr=1 in the second FLUSH cycle and in_valid=1 -> IDLE next cycle, no done, and the offered word not accepted until clr=0.
REQ-033 SHALL be verified with FLUSH_LEN=0 and a single last word -> 4 pixels, then done in the next cycle, with no zero-pixel cycles.
